vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  - 640x480@60 Hz VGA timing generator and pixel output stage. Drives the screen renderers (speed-select, game screens).
//  - Issues pixel_xpos/pixel_ypos one clock ahead of the active window, so a renderer with one cycle of registered latency meets its slot.
//  - Gates the returned pixel_data onto vga_rgb and generates hsync/vsync.
// PARAMETERS
//  H_SYNC   10'd96   hsync pulse width, clocks
//  H_BACK   10'd48   horizontal back porch
//  H_DISP   10'd640  active pixels per line
//  H_FRONT  10'd16   horizontal front porch
//  V_SYNC   10'd2    vsync pulse width, lines
//  V_BACK   10'd33   vertical back porch
//  V_DISP   10'd480  active lines
//  V_FRONT  10'd10   vertical front porch
//  RGB_W    16       colour width (RGB565)
// PORTS
//  vga_clk_25   in   1      25 MHz pixel clock
//  rst_n        in   1      asynchronous active-low reset
//  pixel_data   in   RGB_W  colour from renderer, valid 1 clk after request
//  pixel_xpos   out  10     requested x, 0..639; 0 when no request
//  pixel_ypos   out  10     requested y, 0..479; 0 when no request
//  data_req     out  1      high while pixel_xpos/pixel_ypos are a valid request
//  vga_en       out  1      active video window
//  vga_hs       out  1      hsync, active-low
//  vga_vs       out  1      vsync, active-low
//  vga_rgb      out  RGB_W  colour to DAC
//  frame_start  out  1      1-clk pulse at h_cnt==0 && v_cnt==0
//  test_mode    in   1      present only with VGA_TEST_PATTERN_EN
// BEHAVIOUR
//  - Reset is asynchronous; clocking is on the vga_clk_25 rising edge.
//  - Counters:
//    - H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
//    - h_cnt 0..H_TOTAL-1 wraps to 0.
//    - v_cnt increments only on an h_cnt wrap and wraps 524->0 on that same edge.
//  - Line/frame order: sync, back porch, display, front porch.
//    - vga_hs = 0 iff h_cnt < H_SYNC.
//    - vga_vs = 0 iff v_cnt < V_SYNC.
//  - Active window:
//    - vga_en = 1 iff h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) = [144,784).
//    - It also requires v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP) = [35,515).
//  - Request:
//    - data_req uses the same v range and h range [143,783), i.e. it leads vga_en by exactly 1 clk.
//    - pixel_xpos = h_cnt-143, pixel_ypos = v_cnt-35 while data_req=1; both 0 otherwise.
//  - vga_rgb = vga_en ? pixel_data : 0. The path is combinational and adds no extra latency.
//  - Sync/enable/frame_start decode combinationally from registered counters; outputs are glitch-tolerant at the DAC.
//  - Reset values:
//    - h_cnt = v_cnt = 0.
//    - vga_hs = 0, vga_vs = 0 (counters sit in the sync region).
//    - vga_en = 0, data_req = 0, pixel_xpos/ypos = 0, vga_rgb = 0.
//    - frame_start = 1 while held in reset.
//  - Reset mid-frame: counters return to 0 immediately. The first edge after release continues from 0. No partial-line compensation.
//  - All counter arithmetic is 10-bit unsigned; the subtractions are only evaluated inside the request window, so no underflow is visible.
// CONFIGURATION
//  - VGA_TEST_PATTERN_EN defined:
//    - Adds input test_mode.
//    - test_mode=1 -> vga_rgb ignores pixel_data and shows 8 vertical 80-px bars during vga_en.
//    - Bar order by (h_cnt-144)/80: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
//    - test_mode=0 -> normal path.
//  - VGA_TEST_PATTERN_EN undefined: no test_mode port; behaviour as above.
// TESTING
//  1. Reset release -> vga_hs low 96 clks, high 704, period 800. vga_vs low 1600 clks, period 420000.
//  2. Line v_cnt=35 -> data_req rises at h_cnt=143 with xpos=0/ypos=0. xpos=639 at h_cnt=782. data_req falls at 783.
//  3. Same line -> vga_en high h_cnt 144..783 exactly (640 clks). Low on v_cnt 34 and 515.
//  4. pixel_data held 16'hF800 -> vga_rgb=F800 only while vga_en. 0 in all porches and sync. 307200 F800 clks per frame.
//  5. Assert rst_n at v_cnt=200,h_cnt=400 for 3 clks -> all outputs at reset values. frame_start=1. Counting resumes from 0.
//  6. (VGA_TEST_PATTERN_EN) test_mode=1, pixel_data=1234 -> rgb FFFF at h_cnt 144..223, FFE0 at 224..303, ... 0000 at 704..783.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA timing generator and pixel output stage.
// Free-running h/v counters; sync, enable, request and frame_start decode
// combinationally from the registered counters. The request coordinates lead
// the active window by one clock, so a renderer with one registered stage
// returns pixel_data exactly when vga_en is high.
// Optional build macro: VGA_TEST_PATTERN_EN adds input test_mode, which
// replaces pixel_data with eight 80-pixel vertical colour bars.
module vga_timing_gen #(
    parameter logic [9:0] H_SYNC  = 10'd96,
    parameter logic [9:0] H_BACK  = 10'd48,
    parameter logic [9:0] H_DISP  = 10'd640,
    parameter logic [9:0] H_FRONT = 10'd16,
    parameter logic [9:0] V_SYNC  = 10'd2,
    parameter logic [9:0] V_BACK  = 10'd33,
    parameter logic [9:0] V_DISP  = 10'd480,
    parameter logic [9:0] V_FRONT = 10'd10,
    parameter int         RGB_W   = 16
) (
    input  logic             vga_clk_25,
    input  logic             rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    input  logic [RGB_W-1:0] pixel_data,
    output logic [9:0]       pixel_xpos,
    output logic [9:0]       pixel_ypos,
    output logic             data_req,
    output logic             vga_en,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             frame_start
);

    localparam logic [9:0] H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [9:0] V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
    localparam logic [9:0] H_ACT_END   = H_ACT_START + H_DISP;
    localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
    localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;
    localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
    localparam logic [9:0] V_ACT_END   = V_ACT_START + V_DISP;

    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             v_act;
    logic [RGB_W-1:0] rgb_src;

    // Horizontal counter wraps each line; vertical advances only on that wrap.
    always_ff @(posedge vga_clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_TOTAL - 10'd1) begin
            h_cnt <= 10'd0;
            if (v_cnt == V_TOTAL - 10'd1)
                v_cnt <= 10'd0;
            else
                v_cnt <= v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Sync, window and request decode from the registered counters.
    always_comb begin
        v_act       = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
        vga_hs      = (h_cnt >= H_SYNC);
        vga_vs      = (v_cnt >= V_SYNC);
        vga_en      = v_act && (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
        data_req    = v_act && (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
        frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        // Subtractions are only exposed inside the request window.
        pixel_xpos  = data_req ? (h_cnt - H_REQ_START) : 10'd0;
        pixel_ypos  = data_req ? (v_cnt - V_ACT_START) : 10'd0;
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] bar_idx;

    // Colour source: bar pattern in test mode, renderer data otherwise.
    always_comb begin
        bar_idx = (h_cnt - H_ACT_START) / 10'd80;
        rgb_src = pixel_data;
        if (test_mode) begin
            case (bar_idx)
                10'd0:   rgb_src = RGB_W'(16'hFFFF);
                10'd1:   rgb_src = RGB_W'(16'hFFE0);
                10'd2:   rgb_src = RGB_W'(16'h07FF);
                10'd3:   rgb_src = RGB_W'(16'h07E0);
                10'd4:   rgb_src = RGB_W'(16'hF81F);
                10'd5:   rgb_src = RGB_W'(16'hF800);
                10'd6:   rgb_src = RGB_W'(16'h001F);
                default: rgb_src = RGB_W'(16'h0000);
            endcase
        end
    end
`else
    // Colour source is always the renderer in the default build.
    always_comb begin
        rgb_src = pixel_data;
    end
`endif

    // Blank the DAC outside the active window; no added latency.
    always_comb begin
        vga_rgb = vga_en ? rgb_src : '0;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table of (v,h) sample points with hand-computed
// outputs, plus hand-written sequences for line enable width, sync pulse
// counts, mid-frame reset and (when built with VGA_TEST_PATTERN_EN) bars.
module tb_vga_timing_gen;

    logic        vga_clk_25 = 1'b0;
    logic        rst_n;
    logic [15:0] pixel_data;
    logic [9:0]  pixel_xpos, pixel_ypos;
    logic        data_req, vga_en, vga_hs, vga_vs, frame_start;
    logic [15:0] vga_rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #20 vga_clk_25 = ~vga_clk_25;

    vga_timing_gen dut (
        .vga_clk_25 (vga_clk_25),
        .rst_n      (rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .pixel_data (pixel_data),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .data_req   (data_req),
        .vga_en     (vga_en),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_rgb    (vga_rgb),
        .frame_start(frame_start)
    );

    typedef struct {
        int          v;
        int          h;
        logic [15:0] pd;
        logic        hs, vs, en, req, fs;
        logic [9:0]  x, y;
        logic [15:0] rgb;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk_25);
        #1;
        cyc++;
    endtask

    // Advance until the counters (cycles since release) reach line v, column h.
    task automatic go(input int v, input int h);
        int pos;
        pos = v * 800 + h;
        if (pos < cyc) begin
            chk($sformatf("go_order_v%0d_h%0d", v, h), 32'(cyc), 32'(pos));
        end else begin
            while (cyc < pos) step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hs"}, 32'(vga_hs), 32'd0);
        chk({tag, "_vs"}, 32'(vga_vs), 32'd0);
        chk({tag, "_en"}, 32'(vga_en), 32'd0);
        chk({tag, "_req"}, 32'(data_req), 32'd0);
        chk({tag, "_x"}, 32'(pixel_xpos), 32'd0);
        chk({tag, "_y"}, 32'(pixel_ypos), 32'd0);
        chk({tag, "_rgb"}, 32'(vga_rgb), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd1);
    endtask

    initial begin
        int en_cnt, rgb_cnt, leak_cnt, hs_lo0, hs_lo1, vs_lo, fs_cnt;
        logic [15:0] bars[8];
        string n;

        //          v    h   pd        hs vs en rq fs x    y  rgb
        tbl[0]  = '{  0,   0, 16'hF800, 0, 0, 0, 0, 1, 0,   0, 16'h0000};
        tbl[1]  = '{  0,  95, 16'hF800, 0, 0, 0, 0, 0, 0,   0, 16'h0000};
        tbl[2]  = '{  0,  96, 16'hF800, 1, 0, 0, 0, 0, 0,   0, 16'h0000};
        tbl[3]  = '{  1, 799, 16'hF800, 1, 0, 0, 0, 0, 0,   0, 16'h0000};
        tbl[4]  = '{  2,   0, 16'hF800, 0, 1, 0, 0, 0, 0,   0, 16'h0000};
        tbl[5]  = '{ 34, 500, 16'hF800, 1, 1, 0, 0, 0, 0,   0, 16'h0000};
        tbl[6]  = '{ 35, 142, 16'hF800, 1, 1, 0, 0, 0, 0,   0, 16'h0000};
        tbl[7]  = '{ 35, 143, 16'hF800, 1, 1, 0, 1, 0, 0,   0, 16'h0000};
        tbl[8]  = '{ 35, 144, 16'hF800, 1, 1, 1, 1, 0, 1,   0, 16'hF800};
        tbl[9]  = '{ 35, 782, 16'h1234, 1, 1, 1, 1, 0, 639, 0, 16'h1234};
        tbl[10] = '{ 35, 783, 16'hF800, 1, 1, 1, 0, 0, 0,   0, 16'hF800};
        tbl[11] = '{ 35, 784, 16'hF800, 1, 1, 0, 0, 0, 0,   0, 16'h0000};
        tbl[12] = '{ 36, 500, 16'h07E0, 1, 1, 1, 1, 0, 357, 1, 16'h07E0};

        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

        rst_n = 1'b0;
        pixel_data = 16'hF800;
`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        repeat (3) @(posedge vga_clk_25);
        #1;
        check_reset_outputs("por");

        @(negedge vga_clk_25);
        rst_n = 1'b1;
        cyc = 0;

        for (int i = 0; i < 13; i++) begin
            go(tbl[i].v, tbl[i].h);
            pixel_data = tbl[i].pd;
            #1;
            n = $sformatf("vec%0d_v%0d_h%0d", i, tbl[i].v, tbl[i].h);
            chk({n, "_hs"}, 32'(vga_hs), 32'(tbl[i].hs));
            chk({n, "_vs"}, 32'(vga_vs), 32'(tbl[i].vs));
            chk({n, "_en"}, 32'(vga_en), 32'(tbl[i].en));
            chk({n, "_req"}, 32'(data_req), 32'(tbl[i].req));
            chk({n, "_fs"}, 32'(frame_start), 32'(tbl[i].fs));
            chk({n, "_x"}, 32'(pixel_xpos), 32'(tbl[i].x));
            chk({n, "_y"}, 32'(pixel_ypos), 32'(tbl[i].y));
            chk({n, "_rgb"}, 32'(vga_rgb), 32'(tbl[i].rgb));
        end

        // Whole line 37: exactly 640 enabled clocks, colour only inside them.
        pixel_data = 16'hF800;
        go(37, 0);
        en_cnt = 0; rgb_cnt = 0; leak_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            if (k > 0) step();
            if (vga_en) en_cnt++;
            if (vga_rgb == 16'hF800) rgb_cnt++;
            if (!vga_en && vga_rgb != 16'h0000) leak_cnt++;
        end
        chk("line37_en_clks", 32'(en_cnt), 32'd640);
        chk("line37_rgb_clks", 32'(rgb_cnt), 32'd640);
        chk("line37_blank_leak", 32'(leak_cnt), 32'd0);

`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b1;
        pixel_data = 16'h1234;
        for (int b = 0; b < 8; b++) begin
            go(38, 144 + 80 * b);
            chk($sformatf("bar%0d_first", b), 32'(vga_rgb), 32'(bars[b]));
            go(38, 223 + 80 * b);
            chk($sformatf("bar%0d_last", b), 32'(vga_rgb), 32'(bars[b]));
        end
        go(38, 784);
        chk("bar_after_window", 32'(vga_rgb), 32'd0);
        test_mode = 1'b0;
        pixel_data = 16'hF800;
`endif

        // Mid-frame reset: outputs snap to reset values immediately.
        go(39, 400);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst_now");
        repeat (3) @(posedge vga_clk_25);
        #1;
        check_reset_outputs("midrst_held");
        @(negedge vga_clk_25);
        rst_n = 1'b1;
        cyc = 0;

        // Counting resumes from 0: sync pulse widths and frame_start after release.
        hs_lo0 = 0; hs_lo1 = 0; vs_lo = 0; fs_cnt = 0;
        for (int k = 0; k < 2400; k++) begin
            if (k > 0) step();
            if (k == 1) chk("resume_fs_k1", 32'(frame_start), 32'd0);
            if (!vga_hs && k < 800) hs_lo0++;
            if (!vga_hs && k >= 800 && k < 1600) hs_lo1++;
            if (!vga_vs) vs_lo++;
            if (k == 96) chk("resume_hs_rise_k96", 32'(vga_hs), 32'd1);
            if (k == 800) chk("resume_hs_fall_k800", 32'(vga_hs), 32'd0);
            if (k == 1600) chk("resume_vs_rise_k1600", 32'(vga_vs), 32'd1);
            if (frame_start) fs_cnt++;
        end
        chk("resume_hs_low_line0", 32'(hs_lo0), 32'd96);
        chk("resume_hs_low_line1", 32'(hs_lo1), 32'd96);
        chk("resume_vs_low_clks", 32'(vs_lo), 32'd1600);
        chk("resume_fs_pulses", 32'(fs_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
